// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and default latencies for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_MADD  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational next-HI/LO for the latched op; MADD accumulate is built only with MDU_MADD_EN.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic        [2*WIDTH-1:0] a_zx, b_zx, prod_u;
  logic signed [WIDTH-1:0]   a_s, b_s, quo_s, rem_s;
  logic        [WIDTH-1:0]   quo_u, rem_u;
  logic                      div_zero, div_ovf;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign a_s      = a;
  assign b_s      = b;
  assign quo_s    = a_s / b_s;
  assign rem_s    = a_s % b_s;
  assign quo_u    = a / b;
  assign rem_u    = a % b;
  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == '1);

  always_comb begin
    hi_nxt = hi_cur;
    lo_nxt = lo_cur;
    case (op)
      MD_MULT:  {hi_nxt, lo_nxt} = prod_s;
      MD_MULTU: {hi_nxt, lo_nxt} = prod_u;
      MD_DIV: begin
        // Zero divisor and the single signed overflow case have fixed results.
        if (div_zero) begin
          hi_nxt = a;
          lo_nxt = '1;
        end else if (div_ovf) begin
          hi_nxt = '0;
          lo_nxt = MOST_NEG;
        end else begin
          hi_nxt = rem_s;
          lo_nxt = quo_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          hi_nxt = a;
          lo_nxt = '1;
        end else begin
          hi_nxt = rem_u;
          lo_nxt = quo_u;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD:  {hi_nxt, lo_nxt} = {hi_cur, lo_cur} + prod_s;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO registers; op 7 (MADD) exists only with MDU_MADD_EN.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             is_mul, is_div, accept;

`ifdef MDU_MADD_EN
  assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU) || (md_op == MD_MADD);
`else
  assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
`endif
  assign is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign accept = (state == IDLE) && start;

  // Stage p0: operand latch, captured only when a request is taken in IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= md_op;
      a_p0  <= src_a;
      b_p0  <= src_b;
    end
  end

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (op_p0),
    .a      (a_p0),
    .b      (b_p0),
    .hi_cur (hi),
    .lo_cur (lo),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Control FSM; HI/LO commit on the same edge that drops busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              cnt   <= CW'(MULT_CYCLES);
              busy  <= 1'b1;
              state <= RUN;
            end else if (is_div) begin
              cnt   <= CW'(DIV_CYCLES);
              busy  <= 1'b1;
              state <= RUN;
            end else if (md_op == MD_MTHI) begin
              hi <= src_a;
            end else if (md_op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
